tim_arbiter: RTL and testbench
==============================

# tim_arbiter

Two-port request arbiter that shares the single external memory bus between the instruction TIM (itim) refill port and the data TIM (dtim) refill/load-store port. It sits between both TIM controllers and the memory interconnect. It captures requests, buffers at most one waiting request per port, and grants the bus round-robin or with fixed priority. Responses are routed back to the granted port with zero added latency.

## Interface
- `arb_prio`, default 0: 0 = round-robin; 1 = fixed priority, dport always wins a tie.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `iarb_in`  in  mem_in_type  request from the itim memory side.
- `iarb_out`  out  mem_out_type  response to itim.
- `darb_in`  in  mem_in_type  request from the dtim memory side.
- `darb_out`  out  mem_out_type  response to dtim.
- `mem_out`  in  mem_out_type  response from the memory bus.
- `mem_in`  out  mem_in_type  request to the memory bus.

## Operation
- Request: `mem_valid`=1 in a cycle where that port is idle, meaning it has no buffered request and no transaction in flight. Fields `mem_addr`, `mem_wdata`, `mem_wstrb`, `mem_instr` and `mem_fence` are captured and forwarded unchanged.
- Valid asserted while the port is not idle is a protocol violation. The request is dropped and never forwarded.
- States:
  - IDLE: no transaction in flight.
  - BUSY: `mem_in` holds a registered request for grant port `gnt`.
- Arbitration point: any edge where the state is IDLE, or the state is BUSY with `mem_out.mem_ready`=1.
- Candidates per port, in order of precedence:
  - the buffered request, if present;
  - otherwise a live request. A live request is eligible if the port is idle, or if the port is the one completing this cycle.
- Tie with `arb_prio`=0: grant the port not equal to `last`.
- Tie with `arb_prio`=1: grant dport.
- A losing live request goes into its port's one-entry buffer.
- At the arbitration point:
  - a grant loads the `mem_in` register, sets `gnt` and `last`, and the state becomes BUSY;
  - no candidate: `mem_in` is cleared and the state becomes IDLE.
- Response routing, combinational:
  - `x_out.mem_ready` = `mem_out.mem_ready` & BUSY & (`gnt`==x).
  - `x_out.mem_rdata` = `mem_out.mem_rdata` when BUSY & `gnt`==x, else 0.
- `mem_out.mem_ready` while IDLE is ignored and forwarded to neither port.
- Multi-beat refills are handled as one transaction per beat. The requester presents its next beat in the same cycle it sees ready, and that beat is eligible at the same edge.

## Timing
- Reset asserted, combinationally and asynchronously:
  - `mem_in`=0 (valid, fence, instr, addr, wdata, wstrb all 0);
  - both port outputs `mem_ready`=0, `mem_rdata`=0;
  - both buffers empty; state IDLE; `last`=dport, so the first round-robin tie goes to iport.
- Reset mid-transaction: the in-flight request and both buffered requests are discarded. No ready is delivered after reset deassertion until a new request is issued.
- Latency, request to bus: live request in cycle N while IDLE drives `mem_in.mem_valid`=1 in cycle N+1.
- Latency, response: zero cycles. Ready from memory in cycle M is seen by the granted port in cycle M.
- Back-to-back transactions: a candidate present at the completion edge M gives `mem_in.mem_valid`=1 continuously, with the new request in cycle M+1. No bubble.
- No candidate at completion: `mem_in.mem_valid`=0 from cycle M+1.
- `mem_in` is held stable while BUSY until ready.
- Maximum wait for one port under round-robin: one transaction of the other port.

## Structure
- Package `tim_arbiter_wires` holds:
  - `arb_state_type` (IDLE, BUSY);
  - `arb_port_type` (IPORT, DPORT);
  - `arb_buf_type` (valid bit + mem_in_type fields).
- Sub-module `tim_arbiter_buffer` is the one-entry request holding register with load, clear and full flag. It is instantiated once per port.
- The top holds the state, `gnt`, `last`, the `mem_in` register and the grant logic.

## Test plan
- Single request: itim read 0x0000_1000 in cycle 0. Expect `mem_in.mem_valid`=1 with addr 0x0000_1000 in cycle 1. Memory ready with rdata 0xDEAD_BEEF in cycle 3 gives `iarb_out.mem_ready`=1 and rdata 0xDEAD_BEEF in cycle 3. `darb_out.mem_ready` stays 0.
- Simultaneous requests after reset, `arb_prio`=0: itim addr 0x100 and dtim addr 0x200 in the same cycle.
  - itim is granted first.
  - dtim is buffered and appears on the bus in the cycle after itim's ready, with valid held continuously.
  - Repeating the tie grants dtim first.
- `arb_prio`=1 tie: dport is granted both times.
- Four-beat itim refill: itim presents the next address in each ready cycle while dtim holds a store of wdata 0x1234_5678, strb 0xF.
  - Bus order alternates: i0, d, i1, i2, i3.
  - The store is forwarded with wdata 0x1234_5678, strb 0xF intact.
- Spurious and illegal traffic:
  - ready while IDLE produces no port ready;
  - a second dtim valid while dtim is in flight is never seen on the bus.
- Reset asserted mid-BUSY: `mem_in.mem_valid` falls immediately, both buffers are cleared, and no port ready is seen after release.

Source files
------------

// File: rtl/tim_arbiter_pkg.sv
// Shared types for the TIM memory bus arbiter: bus request/response
// bundles, arbiter state, port ids and the buffered-request record.
package tim_arbiter_wires;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_fence;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_type;

    typedef enum logic {
        IPORT,
        DPORT
    } arb_port_type;

    typedef struct packed {
        logic       valid;
        mem_in_type req;
    } arb_buf_type;

endpackage

// File: rtl/tim_arbiter_buffer.sv
// One-entry request holding register for one arbiter port.
// Ports: clk, rst (async active-low), load/clear, din in; full, dout out.
module tim_arbiter_buffer
    import tim_arbiter_wires::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       clear,
    input  mem_in_type din,
    output logic       full,
    output mem_in_type dout
);

    arb_buf_type slot_q;
    arb_buf_type slot_d;

    // Load wins over clear: a port can hand over its buffered entry
    // and never reloads in the same cycle, but keep the order explicit.
    always_comb begin
        slot_d = slot_q;
        if (clear) begin
            slot_d = '0;
        end
        if (load) begin
            slot_d.valid = 1'b1;
            slot_d.req   = din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign full = slot_q.valid;
    assign dout = slot_q.req;

endmodule

// File: rtl/tim_arbiter.sv
// Shares one memory bus between the itim and dtim refill ports.
// Ports: clk, rst (async active-low), iarb_in/darb_in requests,
// iarb_out/darb_out responses, mem_out bus response, mem_in bus request.
module tim_arbiter
    import tim_arbiter_wires::*;
#(
    parameter bit arb_prio = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  mem_in_type  iarb_in,
    output mem_out_type iarb_out,
    input  mem_in_type  darb_in,
    output mem_out_type darb_out,
    input  mem_out_type mem_out,
    output mem_in_type  mem_in
);

    arb_state_type state_q, state_d;
    arb_port_type  gnt_q, gnt_d;
    arb_port_type  last_q, last_d;
    mem_in_type    mem_in_q, mem_in_d;

    logic       ibuf_full, dbuf_full;
    mem_in_type ibuf_dout, dbuf_dout;
    logic       ibuf_ld, ibuf_clr;
    logic       dbuf_ld, dbuf_clr;

    logic       busy, arb_pt;
    logic       fly_i, fly_d;
    logic       done_i, done_d;
    logic       live_i, live_d;
    logic       cand_i, cand_d;
    logic       pick_d;
    mem_in_type req_i, req_d;

    tim_arbiter_buffer u_ibuf (
        .clk   (clk),
        .rst   (rst),
        .load  (ibuf_ld),
        .clear (ibuf_clr),
        .din   (iarb_in),
        .full  (ibuf_full),
        .dout  (ibuf_dout)
    );

    tim_arbiter_buffer u_dbuf (
        .clk   (clk),
        .rst   (rst),
        .load  (dbuf_ld),
        .clear (dbuf_clr),
        .din   (darb_in),
        .full  (dbuf_full),
        .dout  (dbuf_dout)
    );

    assign busy   = (state_q == BUSY);
    assign fly_i  = busy && (gnt_q == IPORT);
    assign fly_d  = busy && (gnt_q == DPORT);
    assign done_i = fly_i && mem_out.mem_ready;
    assign done_d = fly_d && mem_out.mem_ready;
    assign arb_pt = !busy || mem_out.mem_ready;

    // A live request counts only from an idle port, or from the port
    // whose beat completes now (next refill beat); anything else drops.
    assign live_i = iarb_in.mem_valid && !ibuf_full
                 && (!fly_i || done_i);
    assign live_d = darb_in.mem_valid && !dbuf_full
                 && (!fly_d || done_d);

    assign cand_i = ibuf_full || live_i;
    assign cand_d = dbuf_full || live_d;
    assign req_i  = ibuf_full ? ibuf_dout : iarb_in;
    assign req_d  = dbuf_full ? dbuf_dout : darb_in;

    assign pick_d = cand_d
                 && (!cand_i || arb_prio || (last_q == IPORT));

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        mem_in_d = mem_in_q;
        ibuf_ld  = 1'b0;
        ibuf_clr = 1'b0;
        dbuf_ld  = 1'b0;
        dbuf_clr = 1'b0;
        if (arb_pt) begin
            if (cand_i || cand_d) begin
                state_d = BUSY;
                if (pick_d) begin
                    gnt_d    = DPORT;
                    last_d   = DPORT;
                    mem_in_d = req_d;
                    dbuf_clr = dbuf_full;
                    ibuf_ld  = live_i;
                end else begin
                    gnt_d    = IPORT;
                    last_d   = IPORT;
                    mem_in_d = req_i;
                    ibuf_clr = ibuf_full;
                    dbuf_ld  = live_d;
                end
            end else begin
                state_d  = IDLE;
                mem_in_d = '0;
            end
        end else begin
            ibuf_ld = live_i;
            dbuf_ld = live_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            gnt_q    <= IPORT;
            last_q   <= DPORT;
            mem_in_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            mem_in_q <= mem_in_d;
        end
    end

    always_comb begin
        iarb_out = '0;
        darb_out = '0;
        if (fly_i) begin
            iarb_out = mem_out;
        end
        if (fly_d) begin
            darb_out = mem_out;
        end
    end

    assign mem_in = mem_in_q;

endmodule

// File: tb/tb_tim_arbiter.sv
// Directed bench for tim_arbiter: one round-robin and one fixed-priority
// instance share stimulus; table vectors plus multi-cycle sequences.
module tb_tim_arbiter;
    import tim_arbiter_wires::*;

    logic        clk;
    logic        rst_n;
    mem_in_type  iin, din;
    mem_out_type mout;
    mem_out_type io0, do0, io1, do1;
    mem_in_type  mi0, mi1;

    int checks   = 0;
    int failures = 0;

    logic [31:0] st_wd;
    logic [3:0]  st_ws;

    tim_arbiter #(.arb_prio(1'b0)) u_rr (
        .clk      (clk),
        .rst      (rst_n),
        .iarb_in  (iin),
        .iarb_out (io0),
        .darb_in  (din),
        .darb_out (do0),
        .mem_out  (mout),
        .mem_in   (mi0)
    );

    tim_arbiter #(.arb_prio(1'b1)) u_fp (
        .clk      (clk),
        .rst      (rst_n),
        .iarb_in  (iin),
        .iarb_out (io1),
        .darb_in  (din),
        .darb_out (do1),
        .mem_out  (mout),
        .mem_in   (mi1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic [31:0] da;
        logic        rdy;
        logic [31:0] rd;
        logic        emv;
        logic [31:0] ema;
        logic [31:0] epa;
        logic        eir;
        logic [31:0] eird;
        logic        edr;
        logic [31:0] edrd;
    } vec_t;

    vec_t tv[15];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1ns later.
    task automatic cyc(input logic iv, input logic [31:0] ia,
                       input logic dv, input logic [31:0] da,
                       input logic rdy, input logic [31:0] rd);
        @(negedge clk);
        iin = '0;
        iin.mem_valid = iv;
        iin.mem_instr = iv;
        iin.mem_addr  = ia;
        din = '0;
        din.mem_valid = dv;
        din.mem_addr  = da;
        din.mem_wdata = dv ? st_wd : 32'h0;
        din.mem_wstrb = dv ? st_ws : 4'h0;
        mout.mem_ready = rdy;
        mout.mem_rdata = rd;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        iin  = '0;
        din  = '0;
        mout = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        iin   = '0;
        din   = '0;
        mout  = '0;
        st_wd = 32'h0;
        st_ws = 4'h0;

        // Reset state, with a stray ready on the bus.
        #2;
        rst_n = 1'b0;
        mout.mem_ready = 1'b1;
        mout.mem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("rst_mem_in", mi0, '0);
        chk("rst_iready", {31'h0, io0.mem_ready}, 0);
        chk("rst_drdata", do0.mem_rdata, 0);
        do_reset();

        //        iv  ia     dv  da     rdy rd     emv ema    epa    eir eird          edr edrd
        tv[0]  = '{1, 'h100, 1, 'h200, 0, 0,     0, 0,     0,     0, 0,            0, 0};
        tv[1]  = '{0, 0,     0, 0,     0, 0,     1, 'h100, 'h200, 0, 0,            0, 0};
        tv[2]  = '{0, 0,     0, 0,     1, 'h11,  1, 'h100, 'h200, 1, 'h11,         0, 0};
        tv[3]  = '{0, 0,     0, 0,     0, 0,     1, 'h200, 'h100, 0, 0,            0, 0};
        tv[4]  = '{0, 0,     0, 0,     1, 'h22,  1, 'h200, 'h100, 0, 0,            1, 'h22};
        tv[5]  = '{1, 'h1000,0, 0,     0, 0,     0, 0,     0,     0, 0,            0, 0};
        tv[6]  = '{0, 0,     0, 0,     0, 0,     1, 'h1000,'h1000,0, 0,            0, 0};
        tv[7]  = '{0, 0,     0, 0,     0, 0,     1, 'h1000,'h1000,0, 0,            0, 0};
        tv[8]  = '{0, 0,     0, 0,     1, 'hDEADBEEF,1,'h1000,'h1000,1,'hDEADBEEF, 0, 0};
        tv[9]  = '{1, 'h104, 1, 'h204, 0, 0,     0, 0,     0,     0, 0,            0, 0};
        tv[10] = '{0, 0,     0, 0,     0, 0,     1, 'h204, 'h204, 0, 0,            0, 0};
        tv[11] = '{0, 0,     0, 0,     1, 'h33,  1, 'h204, 'h204, 0, 0,            1, 'h33};
        tv[12] = '{0, 0,     0, 0,     0, 0,     1, 'h104, 'h104, 0, 0,            0, 0};
        tv[13] = '{0, 0,     0, 0,     1, 'h44,  1, 'h104, 'h104, 1, 'h44,         0, 0};
        tv[14] = '{0, 0,     0, 0,     0, 0,     0, 0,     0,     0, 0,            0, 0};

        for (int i = 0; i < 15; i++) begin
            cyc(tv[i].iv, tv[i].ia, tv[i].dv, tv[i].da,
                tv[i].rdy, tv[i].rd);
            chk($sformatf("v%0d_mv", i), {31'h0, mi0.mem_valid},
                {31'h0, tv[i].emv});
            chk($sformatf("v%0d_ma", i), mi0.mem_addr, tv[i].ema);
            chk($sformatf("v%0d_pa", i), mi1.mem_addr, tv[i].epa);
            chk($sformatf("v%0d_ir", i), {31'h0, io0.mem_ready},
                {31'h0, tv[i].eir});
            chk($sformatf("v%0d_ird", i), io0.mem_rdata, tv[i].eird);
            chk($sformatf("v%0d_dr", i), {31'h0, do0.mem_ready},
                {31'h0, tv[i].edr});
            chk($sformatf("v%0d_drd", i), do0.mem_rdata, tv[i].edrd);
        end

        // Four-beat itim refill interleaved with a dtim store.
        do_reset();
        st_wd = 32'h1234_5678;
        st_ws = 4'hF;
        cyc(1, 32'h2000, 1, 32'h3000, 0, 0);
        chk("rf_c0_mv", {31'h0, mi0.mem_valid}, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rf_i0_addr", mi0.mem_addr, 32'h2000);
        chk("rf_i0_instr", {31'h0, mi0.mem_instr}, 1);
        cyc(1, 32'h2004, 0, 0, 1, 32'hA0);
        chk("rf_i0_rdy", {31'h0, io0.mem_ready}, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rf_d_addr", mi0.mem_addr, 32'h3000);
        chk("rf_d_wdata", mi0.mem_wdata, 32'h1234_5678);
        chk("rf_d_wstrb", {28'h0, mi0.mem_wstrb}, 32'hF);
        chk("rf_d_mv", {31'h0, mi0.mem_valid}, 1);
        cyc(0, 0, 0, 0, 1, 32'hA1);
        chk("rf_d_rdy", {31'h0, do0.mem_ready}, 1);
        chk("rf_d_irdy", {31'h0, io0.mem_ready}, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rf_i1_addr", mi0.mem_addr, 32'h2004);
        cyc(1, 32'h2008, 0, 0, 1, 32'hA2);
        chk("rf_i1_rdy", {31'h0, io0.mem_ready}, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rf_i2_addr", mi0.mem_addr, 32'h2008);
        cyc(1, 32'h200C, 0, 0, 1, 32'hA3);
        chk("rf_i2_rdy", {31'h0, io0.mem_ready}, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rf_i3_addr", mi0.mem_addr, 32'h200C);
        cyc(0, 0, 0, 0, 1, 32'hA4);
        chk("rf_i3_rdata", io0.mem_rdata, 32'hA4);
        cyc(0, 0, 0, 0, 0, 0);
        chk("rf_end_mv", {31'h0, mi0.mem_valid}, 0);
        st_wd = 32'h0;
        st_ws = 4'h0;

        // Spurious ready while idle, illegal dtim valid while in flight.
        do_reset();
        cyc(0, 0, 0, 0, 1, 32'h55);
        chk("sp_idle_ir", {31'h0, io0.mem_ready}, 0);
        chk("sp_idle_dr", {31'h0, do0.mem_ready}, 0);
        chk("sp_idle_drd", do0.mem_rdata, 0);
        cyc(0, 0, 1, 32'h4000, 0, 0);
        cyc(0, 0, 1, 32'h5000, 0, 0);
        chk("sp_d_addr", mi0.mem_addr, 32'h4000);
        cyc(0, 0, 0, 0, 1, 32'h66);
        chk("sp_d_rdy", {31'h0, do0.mem_ready}, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("sp_drop_mv", {31'h0, mi0.mem_valid}, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("sp_drop_mv2", {31'h0, mi0.mem_valid}, 0);

        // Reset in the middle of a transaction with dtim buffered.
        do_reset();
        cyc(1, 32'h6000, 1, 32'h7000, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("mr_busy_addr", mi0.mem_addr, 32'h6000);
        mout.mem_ready = 1'b1;
        mout.mem_rdata = 32'h77;
        rst_n = 1'b0;
        #1;
        chk("mr_async_mv", {31'h0, mi0.mem_valid}, 0);
        chk("mr_async_ir", {31'h0, io0.mem_ready}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 0, 1, 32'h77);
            chk($sformatf("mr_post%0d_ir", k),
                {31'h0, io0.mem_ready}, 0);
            chk($sformatf("mr_post%0d_dr", k),
                {31'h0, do0.mem_ready}, 0);
            chk($sformatf("mr_post%0d_mv", k),
                {31'h0, mi0.mem_valid}, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
